alu_rs: RTL

- Reservation station directly upstream of the ALU in the out-of-order RISC-V core.
- Holds up to RS_SIZE dispatched ALU/branch/address micro-ops and tracks operands that are still waiting on ROB tags.
- Snoops the ALU and LSB result broadcasts to resolve those operands.
- Each cycle, issues at most one fully ready entry to the ALU through the execute/type/val1/val2/entry/nowPC interface.

---
 rtl/alu_rs_if.sv | 62 ++++++
 rtl/alu_rs.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, result-broadcast and issue bundle of the ALU reservation station
//
// Purpose: groups every bus signal between the dispatcher, the ALU/LSB result
// broadcasts, the ALU issue port and the reservation station.
// Modports:
//   master - dispatcher/broadcast driver side: drives dispatch_* and the
//            alu_*/lsb_* broadcasts, observes rs_full and the issue outputs.
//   slave  - reservation station side.
// Signals:
//   dispatch_*            new micro-op, operand values/tags, destination tag, pc
//   alu_*/lsb_*           result broadcasts (ready strobe, tag, value)
//   rs_full               no free entry
//   execute/op_type/val1/val2/entry/nowPC  registered issue to the ALU;
//   op_type carries the op encoding (the word "type" is reserved in SV).
interface alu_rs_if #(
  parameter int ID_WIDTH   = 4,
  parameter int VAL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 7
);
  logic                  dispatch_valid;
  logic [OP_WIDTH-1:0]   dispatch_type;
  logic [VAL_WIDTH-1:0]  dispatch_val1;
  logic                  dispatch_dep1_valid;
  logic [ID_WIDTH-1:0]   dispatch_dep1;
  logic [VAL_WIDTH-1:0]  dispatch_val2;
  logic                  dispatch_dep2_valid;
  logic [ID_WIDTH-1:0]   dispatch_dep2;
  logic [ID_WIDTH-1:0]   dispatch_entry;
  logic [ADDR_WIDTH-1:0] dispatch_pc;

  logic                  alu_ready;
  logic [ID_WIDTH-1:0]   alu_entry;
  logic [VAL_WIDTH-1:0]  alu_val;
  logic                  lsb_ready;
  logic [ID_WIDTH-1:0]   lsb_entry;
  logic [VAL_WIDTH-1:0]  lsb_val;

  logic                  rs_full;
  logic                  execute;
  logic [OP_WIDTH-1:0]   op_type;
  logic [VAL_WIDTH-1:0]  val1;
  logic [VAL_WIDTH-1:0]  val2;
  logic [ID_WIDTH-1:0]   entry;
  logic [ADDR_WIDTH-1:0] nowPC;

  modport master (
    output dispatch_valid, dispatch_type, dispatch_val1, dispatch_dep1_valid,
           dispatch_dep1, dispatch_val2, dispatch_dep2_valid, dispatch_dep2,
           dispatch_entry, dispatch_pc,
           alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
    input  rs_full, execute, op_type, val1, val2, entry, nowPC
  );

  modport slave (
    input  dispatch_valid, dispatch_type, dispatch_val1, dispatch_dep1_valid,
           dispatch_dep1, dispatch_val2, dispatch_dep2_valid, dispatch_dep2,
           dispatch_entry, dispatch_pc,
           alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
    output rs_full, execute, op_type, val1, val2, entry, nowPC
  );
endinterface

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station holding ALU micro-ops until their operands resolve
//
// Purpose: stores up to RS_SIZE dispatched ALU/branch/address ops, snoops the
// ALU and LSB result broadcasts to resolve pending operand tags, and issues
// the lowest-index ready entry to the ALU each cycle through registered outputs.
// Ports:
//   clk     rising-edge clock
//   rst_in  asynchronous active-low reset
//   rdy_in  global ready; low freezes all state and outputs
//   clear   synchronous mispredict flush
//   bus     alu_rs_if.slave: dispatch, broadcasts, rs_full and issue outputs
// Build option: define RS_BYPASS_EN to let a fully resolved dispatch issue on
// its dispatch edge when no stored entry is ready.
module alu_rs #(
  parameter int RS_SIZE    = 8,
  parameter int ID_WIDTH   = 4,
  parameter int VAL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 7
) (
  input  logic     clk,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  // Control state (reset) kept packed; payload arrays are not reset since
  // nothing reads them while the matching busy bit is low.
  logic [RS_SIZE-1:0]    busy;
  logic [RS_SIZE-1:0]    dep1_valid;
  logic [RS_SIZE-1:0]    dep2_valid;
  logic [OP_WIDTH-1:0]   e_type  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  e_val1  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  e_val2  [RS_SIZE];
  logic [ID_WIDTH-1:0]   e_dep1  [RS_SIZE];
  logic [ID_WIDTH-1:0]   e_dep2  [RS_SIZE];
  logic [ID_WIDTH-1:0]   e_entry [RS_SIZE];
  logic [ADDR_WIDTH-1:0] e_pc    [RS_SIZE];

  logic [RS_SIZE-1:0]    ready;
  logic                  issue_valid;
  logic [IDX_W-1:0]      issue_idx;
  logic [IDX_W-1:0]      free_idx;
  logic                  dispatch_ok;
  logic                  fwd1_pending;
  logic                  fwd2_pending;
  logic [VAL_WIDTH-1:0]  fwd1_val;
  logic [VAL_WIDTH-1:0]  fwd2_val;
  logic                  bypass;
  logic                  store;

  assign ready       = busy & ~dep1_valid & ~dep2_valid;
  assign bus.rs_full = &busy;
  // A dispatch while full is dropped outright.
  assign dispatch_ok = bus.dispatch_valid && !bus.rs_full;

  // Lowest-index ready entry and lowest-index free slot: scanning downward
  // lets the last hit (the lowest index) win.
  always_comb begin : pick
    issue_valid = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_valid = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Same-cycle forwarding of a broadcast into the op being dispatched, so it
  // never waits on a tag that is already being written back this cycle.
  always_comb begin : forward
    fwd1_val     = bus.dispatch_val1;
    fwd1_pending = bus.dispatch_dep1_valid;
    fwd2_val     = bus.dispatch_val2;
    fwd2_pending = bus.dispatch_dep2_valid;
    if (bus.dispatch_dep1_valid) begin
      if (bus.alu_ready && bus.alu_entry == bus.dispatch_dep1) begin
        fwd1_val     = bus.alu_val;
        fwd1_pending = 1'b0;
      end else if (bus.lsb_ready && bus.lsb_entry == bus.dispatch_dep1) begin
        fwd1_val     = bus.lsb_val;
        fwd1_pending = 1'b0;
      end
    end
    if (bus.dispatch_dep2_valid) begin
      if (bus.alu_ready && bus.alu_entry == bus.dispatch_dep2) begin
        fwd2_val     = bus.alu_val;
        fwd2_pending = 1'b0;
      end else if (bus.lsb_ready && bus.lsb_entry == bus.dispatch_dep2) begin
        fwd2_val     = bus.lsb_val;
        fwd2_pending = 1'b0;
      end
    end
  end

`ifdef RS_BYPASS_EN
  // A resolved dispatch goes straight to the ALU only when the issue port is
  // otherwise unused this edge.
  assign bypass = dispatch_ok && !fwd1_pending && !fwd2_pending && !issue_valid;
`else
  assign bypass = 1'b0;
`endif
  assign store = dispatch_ok && !bypass;

  // Control state and issue outputs.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      dep1_valid  <= '0;
      dep2_valid  <= '0;
      bus.execute <= 1'b0;
      bus.op_type <= '0;
      bus.val1    <= '0;
      bus.val2    <= '0;
      bus.entry   <= '0;
      bus.nowPC   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy        <= '0;
        bus.execute <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            if (dep1_valid[i] &&
                ((bus.alu_ready && bus.alu_entry == e_dep1[i]) ||
                 (bus.lsb_ready && bus.lsb_entry == e_dep1[i]))) begin
              dep1_valid[i] <= 1'b0;
            end
            if (dep2_valid[i] &&
                ((bus.alu_ready && bus.alu_entry == e_dep2[i]) ||
                 (bus.lsb_ready && bus.lsb_entry == e_dep2[i]))) begin
              dep2_valid[i] <= 1'b0;
            end
          end
        end

        if (issue_valid) begin
          busy[issue_idx] <= 1'b0;
          bus.execute     <= 1'b1;
          bus.op_type     <= e_type[issue_idx];
          bus.val1        <= e_val1[issue_idx];
          bus.val2        <= e_val2[issue_idx];
          bus.entry       <= e_entry[issue_idx];
          bus.nowPC       <= e_pc[issue_idx];
        end else if (bypass) begin
          bus.execute     <= 1'b1;
          bus.op_type     <= bus.dispatch_type;
          bus.val1        <= fwd1_val;
          bus.val2        <= fwd2_val;
          bus.entry       <= bus.dispatch_entry;
          bus.nowPC       <= bus.dispatch_pc;
        end else begin
          bus.execute     <= 1'b0;
        end

        // free_idx is never busy, so this cannot collide with the issue slot.
        if (store) begin
          busy[free_idx]       <= 1'b1;
          dep1_valid[free_idx] <= fwd1_pending;
          dep2_valid[free_idx] <= fwd2_pending;
        end
      end
    end
  end

  // Entry payload: broadcast values captured and new ops written.
  always_ff @(posedge clk) begin
    if (rdy_in && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          if (dep1_valid[i]) begin
            if (bus.alu_ready && bus.alu_entry == e_dep1[i]) begin
              e_val1[i] <= bus.alu_val;
            end else if (bus.lsb_ready && bus.lsb_entry == e_dep1[i]) begin
              e_val1[i] <= bus.lsb_val;
            end
          end
          if (dep2_valid[i]) begin
            if (bus.alu_ready && bus.alu_entry == e_dep2[i]) begin
              e_val2[i] <= bus.alu_val;
            end else if (bus.lsb_ready && bus.lsb_entry == e_dep2[i]) begin
              e_val2[i] <= bus.lsb_val;
            end
          end
        end
      end
      if (store) begin
        e_type[free_idx]  <= bus.dispatch_type;
        e_val1[free_idx]  <= fwd1_val;
        e_val2[free_idx]  <= fwd2_val;
        e_dep1[free_idx]  <= bus.dispatch_dep1;
        e_dep2[free_idx]  <= bus.dispatch_dep2;
        e_entry[free_idx] <= bus.dispatch_entry;
        e_pc[free_idx]    <= bus.dispatch_pc;
      end
    end
  end
endmodule
